// File: rtl/rob_nway.sv
// N-wide reorder buffer: in-order dispatch, CDB completion, up to NUM_SUPER in-order retires per cycle,
// single-cycle squash on rollback. Define ROB_PARTIAL_DISPATCH_EN to accept partial dispatch groups.
module rob_nway #(
  parameter int NUM_ROB   = 32,
  parameter int NUM_SUPER = 2,
  parameter int PR_W      = 6,
  parameter int AR_W      = 5,
  localparam int IDX_W    = $clog2(NUM_ROB)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                en,
  input  logic [NUM_SUPER-1:0]                dispatch_valid,
  input  logic [NUM_SUPER-1:0][PR_W-1:0]      dispatch_T_idx,
  input  logic [NUM_SUPER-1:0][PR_W-1:0]      dispatch_Told_idx,
  input  logic [NUM_SUPER-1:0][AR_W-1:0]      dispatch_dest_idx,
  input  logic [NUM_SUPER-1:0]                dispatch_halt,
  output logic [NUM_SUPER-1:0]                dispatch_ready,
  output logic [NUM_SUPER-1:0][IDX_W-1:0]     dispatch_ROB_idx,
  input  logic [NUM_SUPER-1:0]                complete_en,
  input  logic [NUM_SUPER-1:0][IDX_W-1:0]     complete_idx,
  input  logic                                rollback_en,
  input  logic [IDX_W-1:0]                    rollback_idx,
  output logic [NUM_SUPER-1:0]                retire_en,
  output logic [NUM_SUPER-1:0][PR_W-1:0]      retire_T_idx,
  output logic [NUM_SUPER-1:0][PR_W-1:0]      retire_Told_idx,
  output logic [NUM_SUPER-1:0][AR_W-1:0]      retire_dest_idx,
  output logic                                halt_out,
  output logic [IDX_W:0]                      count
);

  logic [IDX_W-1:0]               head, tail, head_n, rb_span, rb_count;
  logic [NUM_ROB-1:0]             valid, done, halt_bit, squash;
  logic [PR_W-1:0]                t_mem    [NUM_ROB];
  logic [PR_W-1:0]                told_mem [NUM_ROB];
  logic [AR_W-1:0]                dest_mem [NUM_ROB];
  logic                           halted, rb_hit, acc_ok, ret_ok;
  logic [IDX_W:0]                 free_slots, n_accept, n_retire;
  logic [NUM_SUPER-1:0]           accept;
  logic [NUM_SUPER-1:0][IDX_W-1:0] ret_idx;

  // Ready looks only at registered count; retires this cycle do not free slots.
  always_comb begin
    free_slots = (IDX_W+1)'(NUM_ROB) - count;
    for (int i = 0; i < NUM_SUPER; i++) begin
`ifdef ROB_PARTIAL_DISPATCH_EN
      dispatch_ready[i] = (free_slots > (IDX_W+1)'(i)) && !rollback_en && !halted;
`else
      dispatch_ready[i] = (free_slots >= (IDX_W+1)'(NUM_SUPER)) && !rollback_en && !halted;
`endif
      dispatch_ROB_idx[i] = tail + IDX_W'(i);
    end
  end

  always_comb begin
    accept   = '0;
    n_accept = '0;
    acc_ok   = en;
    for (int i = 0; i < NUM_SUPER; i++) begin
      acc_ok    = acc_ok && dispatch_valid[i] && dispatch_ready[i];
      accept[i] = acc_ok;
      n_accept  = n_accept + (IDX_W+1)'(acc_ok);
    end
  end

  // Retire lanes form a prefix that stops after the first halt.
  always_comb begin
    retire_en       = '0;
    retire_T_idx    = '0;
    retire_Told_idx = '0;
    retire_dest_idx = '0;
    ret_idx         = '0;
    halt_out        = 1'b0;
    n_retire        = '0;
    ret_ok          = en && !halted;
    for (int k = 0; k < NUM_SUPER; k++) begin
      ret_idx[k]         = head + IDX_W'(k);
      retire_en[k]       = ret_ok && valid[ret_idx[k]] && done[ret_idx[k]];
      retire_T_idx[k]    = t_mem[ret_idx[k]];
      retire_Told_idx[k] = told_mem[ret_idx[k]];
      retire_dest_idx[k] = dest_mem[ret_idx[k]];
      halt_out           = halt_out | (retire_en[k] & halt_bit[ret_idx[k]]);
      ret_ok             = retire_en[k] && !halt_bit[ret_idx[k]];
      n_retire           = n_retire + (IDX_W+1)'(retire_en[k]);
    end
    head_n = head + n_retire[IDX_W-1:0];
  end

  // Squash entries whose distance past the branch lies within branch+1 .. tail-1.
  always_comb begin
    rb_hit   = en && rollback_en && valid[rollback_idx];
    rb_span  = tail - rollback_idx - IDX_W'(1);
    rb_count = rollback_idx + IDX_W'(1) - head_n;
    squash   = '0;
    for (int j = 0; j < NUM_ROB; j++) begin
      squash[j] = rb_hit && ((IDX_W'(j) - rollback_idx) != '0) &&
                  ((IDX_W'(j) - rollback_idx) <= rb_span);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      done     <= '0;
      halt_bit <= '0;
      halted   <= 1'b0;
    end else if (en) begin
      for (int i = 0; i < NUM_SUPER; i++)
        if (complete_en[i] && valid[complete_idx[i]]) done[complete_idx[i]] <= 1'b1;
      for (int k = 0; k < NUM_SUPER; k++)
        if (retire_en[k]) valid[ret_idx[k]] <= 1'b0;
      for (int j = 0; j < NUM_ROB; j++)
        if (squash[j]) begin
          valid[j] <= 1'b0;
          done[j]  <= 1'b0;
        end
      for (int i = 0; i < NUM_SUPER; i++)
        if (accept[i]) begin
          valid[dispatch_ROB_idx[i]]    <= 1'b1;
          done[dispatch_ROB_idx[i]]     <= 1'b0;
          halt_bit[dispatch_ROB_idx[i]] <= dispatch_halt[i];
        end
      head <= head_n;
      if (rb_hit) begin
        tail  <= rollback_idx + IDX_W'(1);
        count <= {1'b0, rb_count};
      end else begin
        tail  <= tail + n_accept[IDX_W-1:0];
        count <= count + n_accept - n_retire;
      end
      if (halt_out) halted <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SUPER; i++)
      if (accept[i]) begin
        t_mem[dispatch_ROB_idx[i]]    <= dispatch_T_idx[i];
        told_mem[dispatch_ROB_idx[i]] <= dispatch_Told_idx[i];
        dest_mem[dispatch_ROB_idx[i]] <= dispatch_dest_idx[i];
      end
  end

endmodule

// File: tb/tb_rob_nway.sv
// Directed bench for rob_nway at default parameters (32 entries, 2 wide): fill, wrap,
// rollback across wrap, rollback with retire, halt, enable and reset behaviour.
module tb_rob_nway;
  logic             clock = 1'b0;
  logic             reset, en;
  logic [1:0]       dispatch_valid, dispatch_halt, dispatch_ready;
  logic [1:0][5:0]  dispatch_T_idx, dispatch_Told_idx;
  logic [1:0][4:0]  dispatch_dest_idx;
  logic [1:0][4:0]  dispatch_ROB_idx;
  logic [1:0]       complete_en;
  logic [1:0][4:0]  complete_idx;
  logic             rollback_en;
  logic [4:0]       rollback_idx;
  logic [1:0]       retire_en;
  logic [1:0][5:0]  retire_T_idx, retire_Told_idx;
  logic [1:0][4:0]  retire_dest_idx;
  logic             halt_out;
  logic [5:0]       count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ROB_PARTIAL_DISPATCH_EN
  localparam logic [1:0] READY_AT_31 = 2'b01;
`else
  localparam logic [1:0] READY_AT_31 = 2'b00;
`endif

  rob_nway dut (
    .clock(clock), .reset(reset), .en(en),
    .dispatch_valid(dispatch_valid), .dispatch_T_idx(dispatch_T_idx),
    .dispatch_Told_idx(dispatch_Told_idx), .dispatch_dest_idx(dispatch_dest_idx),
    .dispatch_halt(dispatch_halt), .dispatch_ready(dispatch_ready),
    .dispatch_ROB_idx(dispatch_ROB_idx), .complete_en(complete_en),
    .complete_idx(complete_idx), .rollback_en(rollback_en), .rollback_idx(rollback_idx),
    .retire_en(retire_en), .retire_T_idx(retire_T_idx), .retire_Told_idx(retire_Told_idx),
    .retire_dest_idx(retire_dest_idx), .halt_out(halt_out), .count(count)
  );

  always #5 clock = ~clock;

  function automatic logic [5:0] pay_t(input int e);  return 6'(e + 3);  endfunction
  function automatic logic [5:0] pay_o(input int e);  return 6'(e + 32); endfunction
  function automatic logic [4:0] pay_d(input int e);  return 5'(31 - e); endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic disp(input int e0, input logic [1:0] v, input logic [1:0] h);
    dispatch_valid = v;
    dispatch_halt  = h;
    for (int i = 0; i < 2; i++) begin
      dispatch_T_idx[i]    = pay_t(e0 + i);
      dispatch_Told_idx[i] = pay_o(e0 + i);
      dispatch_dest_idx[i] = pay_d(e0 + i);
    end
    tick();
    dispatch_valid = '0;
    dispatch_halt  = '0;
  endtask

  task automatic cmpl(input logic [1:0] v, input int a, input int b);
    complete_en     = v;
    complete_idx[0] = 5'(a);
    complete_idx[1] = 5'(b);
    tick();
    complete_en = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (dispatch_ready !== 2'b11) begin n_fail++; $display("FAIL reset_ready: got %b want 11", dispatch_ready); end
    n_checks++; if (dispatch_ROB_idx[0] !== 5'd0 || dispatch_ROB_idx[1] !== 5'd1) begin
      n_fail++; $display("FAIL reset_rob_idx: got %0d,%0d want 0,1", dispatch_ROB_idx[0], dispatch_ROB_idx[1]); end
    n_checks++; if (retire_en !== 2'b00 || halt_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_retire: got %b/%b want 00/0", retire_en, halt_out); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 16; c++) disp(2 * c, 2'b11, 2'b00);
    n_checks++; if (count !== 6'd32) begin n_fail++; $display("FAIL fill_count: got %0d want 32", count); end
    n_checks++; if (dispatch_ready !== 2'b00) begin n_fail++; $display("FAIL fill_ready: got %b want 00", dispatch_ready); end
    cmpl(2'b01, 0, 0);
    n_checks++; if (retire_en !== 2'b01) begin n_fail++; $display("FAIL fill_retire_en: got %b want 01", retire_en); end
    n_checks++; if (retire_T_idx[0] !== pay_t(0) || retire_Told_idx[0] !== pay_o(0) || retire_dest_idx[0] !== pay_d(0)) begin
      n_fail++; $display("FAIL fill_payload: got %0d/%0d/%0d want %0d/%0d/%0d", retire_T_idx[0], retire_Told_idx[0],
                         retire_dest_idx[0], pay_t(0), pay_o(0), pay_d(0)); end
    tick();
    n_checks++; if (count !== 6'd31) begin n_fail++; $display("FAIL fill_count_after: got %0d want 31", count); end
    n_checks++; if (dispatch_ready !== READY_AT_31) begin
      n_fail++; $display("FAIL partial_ready: got %b want %b", dispatch_ready, READY_AT_31); end
    n_checks++; if (retire_en !== 2'b00) begin n_fail++; $display("FAIL fill_retire_stop: got %b want 00", retire_en); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int c = 0; c < 15; c++) disp(2 * c, 2'b11, 2'b00);
    for (int c = 0; c < 15; c++) cmpl(2'b11, 2 * c, 2 * c + 1);
    for (int i = 0; i < 40 && count !== 6'd0; i++) tick();
    n_checks++; if (count !== 6'd0 || dispatch_ROB_idx[0] !== 5'd30 || dispatch_ROB_idx[1] !== 5'd31) begin
      n_fail++; $display("FAIL wrap_setup: got count %0d idx %0d,%0d want 0 30,31", count, dispatch_ROB_idx[0], dispatch_ROB_idx[1]); end
    disp(30, 2'b11, 2'b00);
    n_checks++; if (dispatch_ROB_idx[0] !== 5'd0 || dispatch_ROB_idx[1] !== 5'd1) begin
      n_fail++; $display("FAIL wrap_rob_idx: got %0d,%0d want 0,1", dispatch_ROB_idx[0], dispatch_ROB_idx[1]); end
    disp(0, 2'b11, 2'b00);
    cmpl(2'b11, 30, 31);
    n_checks++; if (retire_en !== 2'b11 || retire_T_idx[1] !== pay_t(31)) begin
      n_fail++; $display("FAIL wrap_retire1: got %b T1=%0d want 11 T1=%0d", retire_en, retire_T_idx[1], pay_t(31)); end
    cmpl(2'b11, 0, 1);
    n_checks++; if (retire_en !== 2'b11 || retire_T_idx[0] !== pay_t(0)) begin
      n_fail++; $display("FAIL wrap_retire2: got %b T0=%0d want 11 T0=%0d", retire_en, retire_T_idx[0], pay_t(0)); end
    tick();
    n_checks++; if (retire_en !== 2'b00 || count !== 6'd0 || dispatch_ROB_idx[0] !== 5'd2) begin
      n_fail++; $display("FAIL wrap_end: got %b count %0d tail %0d want 00 0 2", retire_en, count, dispatch_ROB_idx[0]); end
  endtask

  task automatic test_rollback_wrap();
    do_reset();
    for (int c = 0; c < 14; c++) disp(2 * c, 2'b11, 2'b00);
    for (int c = 0; c < 14; c++) cmpl(2'b11, 2 * c, 2 * c + 1);
    for (int i = 0; i < 40 && count !== 6'd0; i++) tick();
    disp(28, 2'b11, 2'b00);
    disp(30, 2'b11, 2'b00);
    disp(0, 2'b11, 2'b00);
    disp(2, 2'b11, 2'b00);
    n_checks++; if (count !== 6'd8 || dispatch_ROB_idx[0] !== 5'd4) begin
      n_fail++; $display("FAIL rbw_setup: got count %0d tail %0d want 8 4", count, dispatch_ROB_idx[0]); end
    rollback_en  = 1'b1;
    rollback_idx = 5'd30;
    #1;
    n_checks++; if (dispatch_ready !== 2'b00) begin n_fail++; $display("FAIL rbw_ready: got %b want 00", dispatch_ready); end
    tick();
    rollback_en = 1'b0;
    n_checks++; if (count !== 6'd3 || dispatch_ROB_idx[0] !== 5'd31) begin
      n_fail++; $display("FAIL rbw_state: got count %0d tail %0d want 3 31", count, dispatch_ROB_idx[0]); end
    cmpl(2'b11, 28, 29);
    n_checks++; if (retire_en !== 2'b11) begin n_fail++; $display("FAIL rbw_retire1: got %b want 11", retire_en); end
    cmpl(2'b11, 30, 1);
    n_checks++; if (retire_en !== 2'b01 || count !== 6'd1) begin
      n_fail++; $display("FAIL rbw_retire2: got %b count %0d want 01 1", retire_en, count); end
    tick();
    n_checks++; if (retire_en !== 2'b00 || count !== 6'd0) begin
      n_fail++; $display("FAIL rbw_end: got %b count %0d want 00 0", retire_en, count); end
  endtask

  task automatic test_rollback_retire();
    do_reset();
    for (int c = 0; c < 6; c++) disp(2 * c, 2'b11, 2'b00);
    cmpl(2'b11, 0, 1);
    cmpl(2'b11, 2, 3);
    cmpl(2'b11, 4, 4);
    for (int i = 0; i < 8 && retire_en !== 2'b00; i++) tick();
    n_checks++; if (count !== 6'd7 || dispatch_ROB_idx[0] !== 5'd12) begin
      n_fail++; $display("FAIL rbr_setup: got count %0d tail %0d want 7 12", count, dispatch_ROB_idx[0]); end
    cmpl(2'b01, 5, 0);
    rollback_en  = 1'b1;
    rollback_idx = 5'd7;
    #1;
    n_checks++; if (retire_en !== 2'b01 || dispatch_ready !== 2'b00) begin
      n_fail++; $display("FAIL rbr_same_cycle: got %b ready %b want 01 00", retire_en, dispatch_ready); end
    tick();
    rollback_en = 1'b0;
    n_checks++; if (count !== 6'd2 || dispatch_ROB_idx[0] !== 5'd8 || retire_en !== 2'b00) begin
      n_fail++; $display("FAIL rbr_state: got count %0d tail %0d ret %b want 2 8 00", count, dispatch_ROB_idx[0], retire_en); end
  endtask

  task automatic test_halt();
    do_reset();
    disp(0, 2'b11, 2'b10);
    disp(2, 2'b11, 2'b00);
    cmpl(2'b11, 0, 1);
    n_checks++; if (retire_en !== 2'b11 || halt_out !== 1'b1 || retire_dest_idx[1] !== pay_d(1)) begin
      n_fail++; $display("FAIL halt_retire: got %b halt %b dest %0d want 11 1 %0d", retire_en, halt_out, retire_dest_idx[1], pay_d(1)); end
    cmpl(2'b11, 2, 3);
    n_checks++; if (retire_en !== 2'b00 || halt_out !== 1'b0 || dispatch_ready !== 2'b00 || count !== 6'd2) begin
      n_fail++; $display("FAIL halt_stop: got %b halt %b ready %b count %0d want 00 0 00 2", retire_en, halt_out, dispatch_ready, count); end
    tick();
    n_checks++; if (retire_en !== 2'b00 || count !== 6'd2) begin
      n_fail++; $display("FAIL halt_sticky: got %b count %0d want 00 2", retire_en, count); end
    do_reset();
    n_checks++; if (dispatch_ready !== 2'b11 || count !== 6'd0) begin
      n_fail++; $display("FAIL halt_reset: got ready %b count %0d want 11 0", dispatch_ready, count); end
  endtask

  task automatic test_enable();
    do_reset();
    disp(0, 2'b11, 2'b00);
    cmpl(2'b11, 0, 1);
    n_checks++; if (retire_en !== 2'b11) begin n_fail++; $display("FAIL en_retire_on: got %b want 11", retire_en); end
    en = 1'b0;
    #1;
    n_checks++; if (retire_en !== 2'b00) begin n_fail++; $display("FAIL en_retire_off: got %b want 00", retire_en); end
    disp(2, 2'b11, 2'b00);
    n_checks++; if (count !== 6'd2) begin n_fail++; $display("FAIL en_hold: got %0d want 2", count); end
    en = 1'b1;
    #1;
    n_checks++; if (retire_en !== 2'b11) begin n_fail++; $display("FAIL en_resume: got %b want 11", retire_en); end
    tick();
    n_checks++; if (count !== 6'd0) begin n_fail++; $display("FAIL en_drain: got %0d want 0", count); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1;
    dispatch_valid = '0; dispatch_halt = '0;
    dispatch_T_idx = '0; dispatch_Told_idx = '0; dispatch_dest_idx = '0;
    complete_en = '0; complete_idx = '0;
    rollback_en = 1'b0; rollback_idx = '0;
    test_reset();
    test_fill();
    test_wrap();
    test_rollback_wrap();
    test_rollback_retire();
    test_halt();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
